// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MULT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_PROD_W  = 16;
    localparam int unsigned DEF_WIN_MAX = 1;

    // Width of an index register that must reach max_val (at least one bit).
    function automatic int unsigned idx_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/sat_updown.sv
// Saturating up/down counter; inc and dec together hold the value.
module sat_updown
    import mult_pkg::*;
#(
    parameter int unsigned MAX = DEF_WIN_MAX,
    parameter int unsigned W   = idx_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_n;

    always_comb begin
        cnt_n = cnt;
        if (clr) begin
            cnt_n = '0;
        end else if (en) begin
            if (inc && !dec && (cnt != W'(MAX))) begin
                cnt_n = cnt + W'(1);
            end else if (dec && !inc && (cnt != '0)) begin
                cnt_n = cnt - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Load/multiply/done controller for the serial shift-add multiplier datapath.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned PROD_W  = DEF_PROD_W,
    parameter int unsigned WIN_MAX = DEF_WIN_MAX,
    localparam int unsigned WIN_W  = idx_width(WIN_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             scroll_l,
    input  logic             scroll_r,
    output logic             load_a,
    output logic             load_b,
    output logic             spm_clr,
    output logic             prod_clr,
    output logic             prod_shift,
    output logic             busy,
    output logic             done,
    output logic [WIN_W-1:0] win
);

    localparam int unsigned CNT_W = $clog2(PROD_W);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             load_a_n;
    logic             load_b_n;
    logic             spm_clr_n;
    logic             prod_clr_n;
    logic             prod_shift_n;
    logic             busy_n;
    logic             done_n;
    logic             win_clr;

    // Next state and phase counter; clr overrides everything including start.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load_a_n = 1'b0;
        if (clr) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_n  = ST_LOAD;
                        cnt_n    = '0;
                        load_a_n = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_n = ST_MULT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                ST_MULT: begin
                    if (cnt == CNT_W'(PROD_W - 1)) begin
                        state_n = ST_DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Moore decode of the next state, registered so outputs track state exactly.
    always_comb begin
        load_b_n     = (state_n == ST_LOAD);
        spm_clr_n    = (state_n == ST_LOAD);
        prod_clr_n   = (state_n == ST_LOAD);
        prod_shift_n = (state_n == ST_MULT);
        busy_n       = (state_n == ST_LOAD) || (state_n == ST_MULT);
        done_n       = (state_n == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            load_a     <= 1'b0;
            load_b     <= 1'b0;
            spm_clr    <= 1'b0;
            prod_clr   <= 1'b0;
            prod_shift <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            load_a     <= load_a_n;
            load_b     <= load_b_n;
            spm_clr    <= spm_clr_n;
            prod_clr   <= prod_clr_n;
            prod_shift <= prod_shift_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Window returns to 0 on abort or on a restart from DONE.
    assign win_clr = clr || ((state == ST_DONE) && start);

    sat_updown #(
        .MAX (WIN_MAX),
        .W   (WIN_W)
    ) u_win (
        .clk (clk),
        .rst (rst),
        .clr (win_clr),
        .en  (state == ST_DONE),
        .inc (scroll_r),
        .dec (scroll_l),
        .cnt (win)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a small serial-multiplier datapath model.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       start;
    logic       scroll_l;
    logic       scroll_r;
    logic       load_a;
    logic       load_b;
    logic       spm_clr;
    logic       prod_clr;
    logic       prod_shift;
    logic       busy;
    logic       done;
    logic [0:0] win;

    int errors = 0;
    int checks = 0;

    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [2:0]  b_cnt;
    logic [2:0]  b_idx;
    logic [16:0] acc;
    logic [16:0] spm_sum;
    logic [15:0] prod;

    mult_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .start      (start),
        .scroll_l   (scroll_l),
        .scroll_r   (scroll_r),
        .load_a     (load_a),
        .load_b     (load_b),
        .spm_clr    (spm_clr),
        .prod_clr   (prod_clr),
        .prod_shift (prod_shift),
        .busy       (busy),
        .done       (done),
        .win        (win)
    );

    always #5 clk = ~clk;

    // Datapath driven by the sequencer enables: multiplier loaded MSB-first,
    // then shifted out LSB-first with sign extension into a serial adder.
    assign b_idx   = load_a ? 3'd0 : b_cnt;
    assign spm_sum = acc + (b_reg[0] ? {{9{a_reg[7]}}, a_reg} : 17'd0);

    always @(posedge clk) begin
        if (load_a) a_reg <= a_in;
        if (load_b) begin
            b_reg <= {b_reg[6:0], b_in[3'd7 - b_idx]};
            b_cnt <= b_idx + 3'd1;
        end
        if (spm_clr) acc <= '0;
        if (prod_clr) prod <= '0;
        if (prod_shift) begin
            acc   <= {spm_sum[16], spm_sum[16:1]};
            prod  <= {spm_sum[0], prod[15:1]};
            b_reg <= {b_reg[7], b_reg[7:1]};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected {load_a,load_b,spm_clr,prod_clr,prod_shift,busy,done} at cycle c after start.
    function automatic logic [6:0] exp_vec(input int c);
        logic ld;
        logic ml;
        ld = (c >= 1) && (c <= 8);
        ml = (c >= 9) && (c <= 24);
        return {c == 1, ld, ld, ld, ml, ld || ml, c >= 25};
    endfunction

    task automatic test_reset;
        rst = 1'b0; clr = 1'b0; start = 1'b1; scroll_l = 1'b0; scroll_r = 1'b0;
        a_in = 8'h00; b_in = 8'h00;
        repeat (3) tick();
        checks++;
        if ({load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done, win} !== 8'h00) begin
            errors++;
            $display("FAIL reset outputs: got %b expected 00000000",
                     {load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done, win});
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset idle after release: got busy/done %b expected 00", {busy, done});
        end
    endtask

    task automatic test_nominal;
        a_in = 8'h0D; b_in = 8'hF6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            checks++;
            if ({load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done} !== exp_vec(c)) begin
                errors++;
                $display("FAIL nominal cycle %0d: got %b expected %b", c,
                         {load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done}, exp_vec(c));
            end
            if (c == 25) begin
                checks++;
                if (prod !== 16'hFF7E) begin
                    errors++;
                    $display("FAIL nominal product: got %h expected ff7e", prod);
                end
            end
            tick();
        end
    endtask

    task automatic test_scroll;
        logic [0:0] exp_win [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       sr      [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       sl      [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            scroll_r = sr[i];
            scroll_l = sl[i];
            tick();
            checks++;
            if ((win !== exp_win[i]) || (done !== 1'b1)) begin
                errors++;
                $display("FAIL scroll step %0d: got win=%b done=%b expected win=%b done=1",
                         i, win, done, exp_win[i]);
            end
        end
        scroll_r = 1'b0;
        scroll_l = 1'b0;
    endtask

    task automatic test_restart;
        int c;
        scroll_r = 1'b1;
        tick();
        scroll_r = 1'b0;
        a_in = 8'h7F; b_in = 8'h7F;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({load_a, busy, done, win} !== 4'b1100) begin
            errors++;
            $display("FAIL restart first cycle: got load_a/busy/done/win %b expected 1100",
                     {load_a, busy, done, win});
        end
        c = 1;
        while (!done && c < 40) begin
            if (c == 12) scroll_r = 1'b1;
            tick();
            scroll_r = 1'b0;
            c++;
            if (c == 13) begin
                checks++;
                if (win !== 1'b0) begin
                    errors++;
                    $display("FAIL scroll in MULT: got win=%b expected 0", win);
                end
            end
        end
        checks++;
        if (c != 25) begin
            errors++;
            $display("FAIL restart done latency: got %0d expected 25", c);
        end
        checks++;
        if (prod !== 16'h3F01) begin
            errors++;
            $display("FAIL restart product: got %h expected 3f01", prod);
        end
    endtask

    task automatic test_clr_done;
        scroll_r = 1'b1;
        tick();
        scroll_r = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({done, win} !== 2'b00) begin
            errors++;
            $display("FAIL clr in DONE: got done/win %b expected 00", {done, win});
        end
    endtask

    task automatic test_ignored_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            checks++;
            if ({load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done} !== exp_vec(c)) begin
                errors++;
                $display("FAIL ignored start cycle %0d: got %b expected %b", c,
                         {load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done}, exp_vec(c));
            end
            start = (c == 5) || (c == 15);
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_abort;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        checks++;
        if ({prod_shift, busy} !== 2'b11) begin
            errors++;
            $display("FAIL abort pre-clr cycle 12: got prod_shift/busy %b expected 11", {prod_shift, busy});
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done} !== 7'b0) begin
                errors++;
                $display("FAIL abort idle %0d: got %b expected 0000000", i,
                         {load_a, load_b, spm_clr, prod_clr, prod_shift, busy, done});
            end
            tick();
        end
    endtask

    task automatic test_clr_beats_start;
        start = 1'b1;
        clr   = 1'b1;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({load_a, load_b, busy, done} !== 4'b0) begin
                errors++;
                $display("FAIL clr+start idle %0d: got load_a/load_b/busy/done %b expected 0000", i,
                         {load_a, load_b, busy, done});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_scroll();
        test_restart();
        test_clr_done();
        test_ignored_start();
        test_abort();
        test_clr_beats_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Sequencing controller for the serial shift-add multiplier datapath: multiplicand register, sign-extending multiplier shift register, serial SPM core and product SIPO. It accepts a one-cycle start pulse from the debounced centre button and drives the register load, SPM clear, product clear and product shift enables through a load phase and a multiply phase. It then holds `done` and lets the user scroll the display window over the product. It runs on the divided system clock and replaces the loose loading/multiplication counters around the datapath with one FSM.

## Interface
- `WIDTH`, default 8: operand width in bits; multiplier load phase lasts `WIDTH` cycles.
- `PROD_W`, default 16: product width; multiply phase lasts `PROD_W` cycles (must equal 2*`WIDTH`).
- `WIN_MAX`, default 1: highest display-window index reachable by scrolling.
- `clk`  in  1  divided system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `clr`  in  1  synchronous abort; returns to IDLE.
- `start`  in  1  one-cycle pulse (debounced BTNC).
- `scroll_l`, `scroll_r`  in  1 each  one-cycle pulses (debounced BTNL/BTNR).
- `load_a`  out  1  one-cycle pulse; multiplicand register captures.
- `load_b`  out  1  multiplier shift register load/shift-in enable.
- `spm_clr`  out  1  clears SPM partial-sum state.
- `prod_clr`  out  1  clears product SIPO.
- `prod_shift`  out  1  product SIPO shift enable.
- `busy`  out  1  high in LOAD and MULT.
- `done`  out  1  high in DONE.
- `win`  out  $clog2(`WIN_MAX`+1)  display-window index.

## Operation
- States: IDLE, LOAD, MULT, DONE.
- IDLE: all outputs 0; `start` -> LOAD, with `load_a`=1 in that same cycle.
- LOAD: `load_b`=`spm_clr`=`prod_clr`=`busy`=1. Phase counter counts 0..`WIDTH`-1; at `WIDTH`-1 -> MULT, counter to 0.
- MULT: `prod_shift`=`busy`=1. Counter counts 0..`PROD_W`-1; at `PROD_W`-1 -> DONE.
- DONE: `done`=1 and held; `start` -> LOAD (restart, `load_a` pulse, `win` reset to 0).
- `start` in LOAD or MULT is ignored; there is no queuing.
- `clr` in any state -> IDLE next cycle, counter 0, `win` 0. `clr` beats a simultaneous `start`.
- Scrolling is accepted only in DONE:
  - `scroll_r` increments `win`, saturating at `WIN_MAX`.
  - `scroll_l` decrements `win`, saturating at 0.
  - Both asserted together: no change.
  - Outside DONE, scroll pulses are ignored.
- Counter width is $clog2(`PROD_W`); the counter never wraps past its terminal value.

## Timing
- Reset (`rst`=0 at edge): state IDLE, counter 0, `win` 0, all outputs 0.
- Outputs are Moore-decoded from registered state, except `load_a`, which is registered alongside the IDLE/DONE -> LOAD transition so that it is high exactly the first LOAD cycle.
- Latency from the `start` edge: LOAD for cycles 1..`WIDTH`; MULT for the next `PROD_W` cycles; `done` rises at cycle `WIDTH`+`PROD_W`+1. With defaults, `done` rises 25 cycles after `start`.
- `busy` and `done` are never high together; `load_b` and `prod_shift` are never high together.
- Reset or `clr` mid-operation: the next cycle is IDLE with no residual pulses. The datapath is left for the next LOAD to clear.

## Structure
- Shared package `mult_pkg`:
  - state enum typedef (IDLE=0, LOAD=1, MULT=2, DONE=3);
  - default `WIDTH`/`PROD_W` constants.
- One sub-module: `sat_updown` (saturating up/down window counter with enable, inputs inc/dec/clr). The phase counter stays inline with the FSM.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 -> all outputs 0, `win`=0, state IDLE.
- Nominal: `start` pulse at cycle 0:
  - `load_a` high only in cycle 1;
  - `load_b` high cycles 1-8;
  - `prod_shift` high cycles 9-24;
  - `done` high from cycle 25 until the next `start`.
- End-to-end with the datapath: multiplicand 0x0D, multiplier 0xF6 (-10) -> product SIPO holds 0xFF7E (-130) when `done` rises; 0x7F x 0x7F -> 0x3F01.
- Abort: `clr` at cycle 12 (in MULT) -> IDLE at cycle 13. `start` and `clr` in the same cycle -> stays IDLE, no `load_a`.
- Ignored start: extra `start` pulses at cycles 5 and 15 -> `done` still rises at cycle 25 exactly.
- Scroll: in DONE, `scroll_r` x3 -> `win`=1 (saturated); `scroll_l`+`scroll_r` together -> unchanged; `scroll_l` x2 -> 0. `scroll_r` during MULT -> `win` stays 0.
